// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage: PC, 1-cycle imem request, fetch queue toward decode
// Optional perf counters perf_fetched/perf_flushed exist only when IF_PERF_CNT_EN is defined.
module if_fetch_stage #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc_plus4
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = PW + 2;

  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic          inflight;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   inst_mem  [DEPTH];
  logic [31:0]   plus4_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [OW-1:0] occupancy;
  logic          pop;
  logic          issue;
  logic          fill;

  // Credit rule: queued + in-flight, after this cycle's pop, must leave room for one more response.
  always_comb begin
    id_valid  = (count != '0) & ~redirect_valid;
    pop       = id_valid & id_ready;
    occupancy = OW'(count) + OW'(inflight) - OW'(pop);
    issue     = ~rst & ~redirect_valid & (occupancy < OW'(DEPTH));
    fill      = inflight;
  end

  assign imem_req    = issue;
  assign imem_addr   = pc;
  assign id_pc       = pc_mem[rd_ptr];
  assign id_inst     = inst_mem[rd_ptr];
  assign id_pc_plus4 = plus4_mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        inst_mem[i]  <= '0;
        plus4_mem[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Flush queue and drop any response still on its way back from imem.
      pc       <= {redirect_pc[31:2], 2'b00};
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (issue) begin
        pc     <= pc + 32'd4;
        req_pc <= pc;
      end
      inflight <= issue;
      if (fill) begin
        pc_mem[wr_ptr]    <= req_pc;
        inst_mem[wr_ptr]  <= imem_rdata;
        plus4_mem[wr_ptr] <= req_pc + 32'd4;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(fill) - CW'(pop);
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (pop) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (redirect_valid) begin
        perf_flushed <= perf_flushed + 32'(count) + 32'(inflight);
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - scoreboard bench for if_fetch_stage (DEPTH=2); perf checks under IF_PERF_CNT_EN
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [31:0] id_pc_plus4;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
  int          exp_flushed = 0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_fetched = 0;

  if_fetch_stage #(.DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_inst        (id_inst),
    .id_pc_plus4    (id_pc_plus4)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  // 1-cycle-latency instruction memory
  always @(posedge clk) begin
    imem_rdata <= imem_req ? mem_f(imem_addr) : 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_stream(input logic [31:0] start);
    logic [31:0] a;
    exp_q.delete();
    a = {start[31:2], 2'b00};
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back('{pc: a, inst: mem_f(a)});
      a = a + 32'd4;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Every instruction accepted by decode must match the head of the expected stream.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_fetched = 0;
    end else if (id_valid && id_ready) begin
      check("sb_avail", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_pc", id_pc, e.pc);
        check("sb_inst", id_inst, e.inst);
        check("sb_plus4", id_pc_plus4, e.pc + 32'd4);
      end
      exp_fetched++;
    end
  end

  initial begin
    rst = 1'b1;
    id_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    mid();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_pc", id_pc, 32'd0);
    check("rst_inst", id_inst, 32'd0);
    check("rst_plus4", id_pc_plus4, 32'd0);

    // streaming from reset
    next_cycle(); rst = 1'b0; expect_stream(32'h0); mid();
    check("a0_req", 32'(imem_req), 32'd1);
    check("a0_addr", imem_addr, 32'h0);
    check("a0_valid", 32'(id_valid), 32'd0);
    next_cycle(); mid();
    check("a1_addr", imem_addr, 32'h4);
    check("a1_valid", 32'(id_valid), 32'd0);
    next_cycle(); mid();
    check("a2_valid", 32'(id_valid), 32'd1);
    check("a2_pc", id_pc, 32'h0);
    next_cycle(); mid(); check("a3_pc", id_pc, 32'h4);
    next_cycle(); mid(); check("a4_pc", id_pc, 32'h8);
    next_cycle(); mid(); check("a5_pc", id_pc, 32'hC);

    // asynchronous reset in the middle of a fill
    next_cycle(); #2 rst = 1'b1; #1;
    check("arst_req", 32'(imem_req), 32'd0);
    check("arst_valid", 32'(id_valid), 32'd0);
    check("arst_pc", id_pc, 32'd0);
    check("arst_inst", id_inst, 32'd0);
    check("arst_plus4", id_pc_plus4, 32'd0);
    @(posedge clk); #1;

    // stall from first valid
    rst = 1'b0; id_ready = 1'b0; expect_stream(32'h0); mid();
    check("b0_req", 32'(imem_req), 32'd1);
    check("b0_addr", imem_addr, 32'h0);
    next_cycle(); mid(); check("b1_addr", imem_addr, 32'h4);
    next_cycle(); mid();
    check("b2_valid", 32'(id_valid), 32'd1);
    check("b2_pc", id_pc, 32'h0);
    check("b2_req", 32'(imem_req), 32'd0);
    for (int i = 3; i <= 6; i++) begin
      next_cycle(); mid();
      check("bstall_pc", id_pc, 32'h0);
      check("bstall_inst", id_inst, mem_f(32'h0));
      check("bstall_req", 32'(imem_req), 32'd0);
    end
    next_cycle(); id_ready = 1'b1; mid();
    check("b7_req", 32'(imem_req), 32'd1);
    check("b7_addr", imem_addr, 32'h8);
    check("b7_pc", id_pc, 32'h0);
    next_cycle(); mid(); check("b8_pc", id_pc, 32'h4);
    next_cycle(); mid(); check("b9_pc", id_pc, 32'h8);
    next_cycle(); id_ready = 1'b0; mid();
    check("b10_pc", id_pc, 32'hC);
    check("b10_req", 32'(imem_req), 32'd0);
    next_cycle(); mid();
    check("b11_valid", 32'(id_valid), 32'd1);
    check("b11_pc", id_pc, 32'hC);

    // redirect with full queue, misaligned target
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h43; expect_stream(32'h40);
`ifdef IF_PERF_CNT_EN
    exp_flushed += 2;
`endif
    mid();
    check("r0_valid", 32'(id_valid), 32'd0);
    check("r0_req", 32'(imem_req), 32'd0);
    next_cycle(); redirect_valid = 1'b0; id_ready = 1'b1; mid();
    check("r1_valid", 32'(id_valid), 32'd0);
    check("r1_req", 32'(imem_req), 32'd1);
    check("r1_addr", imem_addr, 32'h40);
`ifdef IF_PERF_CNT_EN
    check("r1_perf_flushed", perf_flushed, 32'(exp_flushed));
`endif
    next_cycle(); mid();
    check("r2_valid", 32'(id_valid), 32'd0);
    check("r2_addr", imem_addr, 32'h44);
    next_cycle(); mid();
    check("r3_valid", 32'(id_valid), 32'd1);
    check("r3_pc", id_pc, 32'h40);
    next_cycle(); mid();

    // back-to-back redirects: last one wins
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h80; expect_stream(32'h80);
`ifdef IF_PERF_CNT_EN
    exp_flushed += 2;
`endif
    mid(); check("bb0_valid", 32'(id_valid), 32'd0);
    next_cycle(); redirect_pc = 32'h100; expect_stream(32'h100); mid();
    check("bb1_valid", 32'(id_valid), 32'd0);
    check("bb1_req", 32'(imem_req), 32'd0);
    next_cycle(); redirect_valid = 1'b0; mid();
    check("bb2_addr", imem_addr, 32'h100);
    check("bb2_valid", 32'(id_valid), 32'd0);
    next_cycle(); mid(); check("bb3_valid", 32'(id_valid), 32'd0);
    next_cycle(); mid();
    check("bb4_valid", 32'(id_valid), 32'd1);
    check("bb4_pc", id_pc, 32'h100);

    // random decode back-pressure, ordering checked by scoreboard
    repeat (40) begin
      next_cycle(); id_ready = 1'($urandom_range(0, 1)); mid();
    end

    // fill up, then redirect near the top of the address space
    id_ready = 1'b0;
    repeat (3) next_cycle();
    mid(); check("full_req", 32'(imem_req), 32'd0);
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; id_ready = 1'b1;
    expect_stream(32'hFFFF_FFF8);
`ifdef IF_PERF_CNT_EN
    exp_flushed += 2;
`endif
    mid();
    next_cycle(); redirect_valid = 1'b0; mid(); check("w1_addr", imem_addr, 32'hFFFF_FFF8);
    next_cycle(); mid(); check("w2_addr", imem_addr, 32'hFFFF_FFFC);
    next_cycle(); mid();
    check("w3_addr", imem_addr, 32'h0);
    check("w3_pc", id_pc, 32'hFFFF_FFF8);
    next_cycle(); mid();
    check("w4_pc", id_pc, 32'hFFFF_FFFC);
    check("w4_plus4", id_pc_plus4, 32'h0);
    next_cycle(); mid(); check("w5_pc", id_pc, 32'h0);
    next_cycle(); id_ready = 1'b0; mid();
    next_cycle(); mid();
`ifdef IF_PERF_CNT_EN
    check("perf_fetched", perf_fetched, 32'(exp_fetched));
    check("perf_flushed", perf_flushed, 32'(exp_flushed));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
